// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types, limits and width helpers for the UART receive core
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int OVERSAMPLE_MIN = 4;
    localparam int OVERSAMPLE_MAX = 256;
    localparam int DATA_BITS_MIN  = 5;
    localparam int DATA_BITS_MAX  = 9;

    function automatic int tick_width(input int oversample);
        return $clog2(oversample);
    endfunction

    function automatic int bit_cnt_width(input int data_bits);
        return $clog2(data_bits + 1);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - 2-flop serial line synchroniser plus falling-edge detect flop
module uart_rx_sync (
    input  logic clk,
    input  logic gl_reset_n,
    input  logic din,
    output logic rx_s,
    output logic fall
);

    logic rx_m;
    logic rx_d;

    // Reset to the idle-high line level so release never looks like a start edge.
    always_ff @(posedge clk) begin
        if (!gl_reset_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= din;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    assign fall = rx_d & ~rx_s;

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - parametrised UART receiver; parity support under UART_RX_PARITY_EN
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE = 8,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 gl_reset_n,
    input  logic                 dIn,
    output logic [DATA_BITS-1:0] dOut,
    output logic                 dValid,
    input  logic                 dReady,
    output logic                 dError,
    output logic                 pError,
    output logic                 overrun,
    output logic                 busy
);

    localparam int TW = tick_width(OVERSAMPLE);
    localparam int BW = bit_cnt_width(DATA_BITS);
    localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
    localparam rx_state_t AFTER_DATA = PARITY;
`else
    localparam rx_state_t AFTER_DATA = STOP;
`endif

    if (OVERSAMPLE < OVERSAMPLE_MIN || OVERSAMPLE > OVERSAMPLE_MAX ||
        DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_param_check
        $error("uart_rx_core: OVERSAMPLE or DATA_BITS out of range");
    end

    logic                 rx_s;
    logic                 fall;
    rx_state_t            state;
    rx_state_t            state_nx;
    logic [TW-1:0]        tick;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 tick_done;
    logic                 load;
    logic                 handshake;
    logic                 par_err;

    uart_rx_sync u_sync (
        .clk        (clk),
        .gl_reset_n (gl_reset_n),
        .din        (dIn),
        .rx_s       (rx_s),
        .fall       (fall)
    );

    always_ff @(posedge clk) begin
        if (!gl_reset_n) state <= IDLE;
        else             state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (fall)      state_nx = START;
            START:  if (tick_done) state_nx = rx_s ? IDLE : DATA;
            DATA:   if (tick_done && bit_cnt == LAST_BIT) state_nx = AFTER_DATA;
`ifdef UART_RX_PARITY_EN
            PARITY: if (tick_done) state_nx = STOP;
`endif
            STOP:   if (tick_done) state_nx = IDLE;
            default:               state_nx = IDLE;
        endcase
    end

    // START waits half a bit to land on mid-bit; every later sample is a full bit apart.
    always_comb begin
        tick_done = 1'b0;
        busy      = (state != IDLE);
        load      = 1'b0;
        case (state)
            START:        tick_done = (tick == HALF_M1);
            DATA, PARITY: tick_done = (tick == FULL_M1);
            STOP: begin
                tick_done = (tick == FULL_M1);
                load      = (tick == FULL_M1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!gl_reset_n) begin
            tick    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            if (state == IDLE || tick_done) tick <= '0;
            else                            tick <= tick + 1'b1;
            if (state != DATA)  bit_cnt <= '0;
            else if (tick_done) bit_cnt <= bit_cnt + 1'b1;
            if (state == DATA && tick_done) shift <= {rx_s, shift[DATA_BITS-1:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!gl_reset_n)                     par_err <= 1'b0;
        else if (state == PARITY && tick_done) par_err <= rx_s ^ (^shift) ^ PARITY_ODD[0];
    end
`else
    logic unused_parity_odd;
    assign unused_parity_odd = PARITY_ODD[0];
    assign par_err           = 1'b0;
`endif

    assign handshake = dValid & dReady;

    // A frame completing while the previous one is still unread is dropped.
    always_ff @(posedge clk) begin
        if (!gl_reset_n) begin
            dOut    <= '0;
            dValid  <= 1'b0;
            dError  <= 1'b0;
            pError  <= 1'b0;
            overrun <= 1'b0;
        end else if (load && dValid && !dReady) begin
            overrun <= 1'b1;
        end else begin
            if (load) begin
                dOut   <= shift;
                dError <= ~rx_s;
                pError <= par_err;
                dValid <= 1'b1;
            end else if (handshake) begin
                dValid <= 1'b0;
            end
            if (handshake) overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - scoreboard bench for uart_rx_core (parity cases with UART_RX_PARITY_EN)
module tb_uart_rx_core;

    localparam int OS = 8;
`ifdef UART_RX_PARITY_EN
    localparam int DB = 7;
    localparam int PB = 1;
`else
    localparam int DB = 8;
    localparam int PB = 0;
`endif

    typedef struct packed {
        logic [DB-1:0] data;
        logic          derr;
        logic          perr;
    } exp_t;

    logic          clk = 1'b0;
    logic          gl_reset_n = 1'b0;
    logic          dIn = 1'b1;
    logic          dReady = 1'b1;
    logic [DB-1:0] dOut;
    logic          dValid;
    logic          dError;
    logic          pError;
    logic          overrun;
    logic          busy;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   rise_cyc = 0;
    int   t_start = 0;
    logic dv_q = 1'b0;

    uart_rx_core #(
        .OVERSAMPLE (OS),
        .DATA_BITS  (DB),
        .PARITY_ODD (0)
    ) dut (
        .clk        (clk),
        .gl_reset_n (gl_reset_n),
        .dIn        (dIn),
        .dOut       (dOut),
        .dValid     (dValid),
        .dReady     (dReady),
        .dError     (dError),
        .pError     (pError),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (dValid && !dv_q) rise_cyc <= cyc;
        dv_q <= dValid;
        if (gl_reset_n && dValid && dReady) begin
            check_eq("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check_eq("dout", 32'(dOut), 32'(mon_e.data));
                check_eq("derr", 32'(dError), 32'(mon_e.derr));
                check_eq("perr", 32'(pError), 32'(mon_e.perr));
            end
        end
    end

    task automatic drive_bit(input logic b);
        @(posedge clk);
        #1 dIn = b;
        repeat (OS - 1) @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1 dIn = 1'b1;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop_b, input logic par_b);
        @(posedge clk);
        #1 dIn = 1'b0;
        t_start = cyc;
        repeat (OS - 1) @(posedge clk);
        for (int i = 0; i < DB; i++) drive_bit(d[i]);
        if (PB != 0) drive_bit(par_b);
        drive_bit(stop_b);
    endtask

    task automatic send_good(input logic [DB-1:0] d);
        sb.push_back('{data: d, derr: 1'b0, perr: 1'b0});
        send_frame(d, 1'b1, ^d);
        idle(OS);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge clk);
        check_eq(tag, 32'(sb.size()), 0);
        #1;
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_dvalid", 32'(dValid), 0);
        check_eq("rst_dout", 32'(dOut), 0);
        check_eq("rst_derr", 32'(dError), 0);
        check_eq("rst_perr", 32'(pError), 0);
        check_eq("rst_overrun", 32'(overrun), 0);
        check_eq("rst_busy", 32'(busy), 0);
        gl_reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Basic frame and latency: dValid rises E+77 where E = drive cycle + 2.
        send_good(DB'(8'hA5));
        wait_drain("drain_a5");
        check_eq("latency", 32'(rise_cyc - t_start), 32'(2 + OS / 2 + (DB + 1 + PB) * OS + 1));
        check_eq("a5_overrun", 32'(overrun), 0);

        // Half-bit glitch.
        @(posedge clk);
        #1 dIn = 1'b0;
        repeat (OS / 2) @(posedge clk);
        #1 dIn = 1'b1;
        check_eq("glitch_busy_start", 32'(busy), 1);
        repeat (2) @(posedge clk);
        #1 check_eq("glitch_busy_e4", 32'(busy), 1);
        @(posedge clk);
        #1 check_eq("glitch_idle", 32'(busy), 0);
        idle(2 * OS);

        // Framing error then a clean frame.
        sb.push_back('{data: DB'(8'h3C), derr: 1'b1, perr: 1'b0});
        send_frame(DB'(8'h3C), 1'b0, ^(DB'(8'h3C)));
        idle(OS);
        send_good(DB'(8'h81));
        wait_drain("drain_stop");

        // Overrun with back-to-back frames.
        dReady = 1'b0;
        sb.push_back('{data: DB'(8'h11), derr: 1'b0, perr: 1'b0});
        send_frame(DB'(8'h11), 1'b1, ^(DB'(8'h11)));
        send_frame(DB'(8'h22), 1'b1, ^(DB'(8'h22)));
        idle(2 * OS);
        #1;
        check_eq("ovr_flag", 32'(overrun), 1);
        check_eq("ovr_valid", 32'(dValid), 1);
        check_eq("ovr_hold", 32'(dOut), 32'(DB'(8'h11)));
        @(posedge clk);
        #1 dReady = 1'b1;
        @(posedge clk);
        #1 dReady = 1'b0;
        check_eq("ovr_valid_clr", 32'(dValid), 0);
        check_eq("ovr_clr", 32'(overrun), 0);
        check_eq("ovr_sb", 32'(sb.size()), 0);
        dReady = 1'b1;

        // Reset during data bit 3 aborts the frame.
        fork
            send_frame(DB'(8'hFF), 1'b1, ^(DB'(8'hFF)));
            begin
                repeat (OS * 4 + OS / 2) @(posedge clk);
                #1 gl_reset_n = 1'b0;
                @(posedge clk);
                #1 gl_reset_n = 1'b1;
                check_eq("midrst_busy", 32'(busy), 0);
                check_eq("midrst_valid", 32'(dValid), 0);
            end
        join
        idle(OS);
        send_good(DB'(8'h0F));
        wait_drain("drain_0f");

`ifdef UART_RX_PARITY_EN
        sb.push_back('{data: DB'(8'h55), derr: 1'b0, perr: 1'b1});
        send_frame(DB'(8'h55), 1'b1, 1'b1);
        idle(OS);
        sb.push_back('{data: DB'(8'h55), derr: 1'b0, perr: 1'b0});
        send_frame(DB'(8'h55), 1'b1, 1'b0);
        idle(OS);
        wait_drain("drain_parity");
`endif

        repeat (OS) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
